// File: rtl/audio_dac_sequencer_if.sv
// Host-side sample write port of the audio DAC sequencer.
// The host pushes {right,left} pairs and watches FIFO occupancy and refill hints.
interface audio_dac_sequencer_if #(
  parameter int FIFO_AW = 4
) ();
  logic             wr_en;
  logic [31:0]      wr_data;
  logic             fifo_full;
  logic [FIFO_AW:0] fifo_level;
  logic             refill_req;

  modport master (
    output wr_en,
    output wr_data,
    input  fifo_full,
    input  fifo_level,
    input  refill_req
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output fifo_full,
    output fifo_level,
    output refill_req
  );
endinterface

// File: rtl/audio_dac_sequencer.sv
// Stereo sample scheduler: buffers host sample pairs and hands one pair per sample
// tick to the DAC, with priming, underrun hold and pop-free shutdown.
module audio_dac_sequencer #(
  parameter int FIFO_AW     = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  shutdown_req,
  input  logic [15:0]           rate_div,
  input  logic                  clr_flags,
  audio_dac_sequencer_if.slave  host,
  output logic [15:0]           d_l,
  output logic [15:0]           d_r,
  output logic                  terminate,
  output logic                  underrun,
  output logic                  overflow
);
  localparam int               DEPTH     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_LVL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] PRIME_LVL = (FIFO_AW + 1)'(PRIME_LEVEL);
  localparam logic [FIFO_AW:0] HALF_LVL  = (FIFO_AW + 1)'(DEPTH / 2);
  localparam logic [FIFO_AW:0] LVL_ZERO  = {(FIFO_AW + 1){1'b0}};
  localparam logic [FIFO_AW:0] LVL_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ZERO = {FIFO_AW{1'b0}};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW - 1){1'b0}}, 1'b1};
  localparam logic [15:0]      SILENCE   = 16'h8000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    RUN      = 3'd2,
    UNDERRUN = 3'd3,
    SHUTDOWN = 3'd4
  } state_t;

  state_t             state_r;
  logic [15:0]        cnt_r;
  logic [FIFO_AW-1:0] wptr_r;
  logic [FIFO_AW-1:0] rptr_r;
  logic [FIFO_AW:0]   level_r;
  logic [31:0]        mem_r [DEPTH];

  logic        tick_s;
  logic        full_s;
  logic        empty_s;
  logic        active_s;
  logic        wr_ok_s;
  logic        ovf_set_s;
  logic        pop_s;
  logic        unf_set_s;
  logic [31:0] rd_data_s;

  // Tick, FIFO status and per-cycle write/pop decisions; a tick only sees pre-write occupancy.
  always_comb begin
    tick_s    = (cnt_r == 16'd0);
    full_s    = (level_r == DEPTH_LVL);
    empty_s   = (level_r == LVL_ZERO);
    active_s  = enable && !shutdown_req &&
                ((state_r == PRIME) || (state_r == RUN) || (state_r == UNDERRUN));
    wr_ok_s   = active_s && host.wr_en && !full_s;
    ovf_set_s = active_s && host.wr_en && full_s;
    pop_s     = active_s && (state_r == RUN) && tick_s && !empty_s;
    unf_set_s = active_s && (state_r == RUN) && tick_s && empty_s;
    rd_data_s = mem_r[rptr_r];
  end

  // Sample storage, deliberately unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wptr_r] <= host.wr_data;
    end
  end

  // Sequencer FSM, tick counter, FIFO pointers, flags and registered DAC outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 16'd0;
      wptr_r    <= PTR_ZERO;
      rptr_r    <= PTR_ZERO;
      level_r   <= LVL_ZERO;
      d_l       <= SILENCE;
      d_r       <= SILENCE;
      terminate <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cnt_r <= tick_s ? rate_div : (cnt_r - 16'd1);

      if (unf_set_s) begin
        underrun <= 1'b1;
      end else if (clr_flags) begin
        underrun <= 1'b0;
      end
      if (ovf_set_s) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end

      if (shutdown_req || (state_r == SHUTDOWN)) begin
        state_r   <= SHUTDOWN;
        terminate <= 1'b1;
        wptr_r    <= PTR_ZERO;
        rptr_r    <= PTR_ZERO;
        level_r   <= LVL_ZERO;
        d_l       <= SILENCE;
        d_r       <= SILENCE;
      end else begin
        case (state_r)
          IDLE: begin
            wptr_r  <= PTR_ZERO;
            rptr_r  <= PTR_ZERO;
            level_r <= LVL_ZERO;
            d_l     <= SILENCE;
            d_r     <= SILENCE;
            if (enable) begin
              state_r <= PRIME;
            end
          end
          PRIME, RUN, UNDERRUN: begin
            if (!enable) begin
              state_r <= IDLE;
              wptr_r  <= PTR_ZERO;
              rptr_r  <= PTR_ZERO;
              level_r <= LVL_ZERO;
              d_l     <= SILENCE;
              d_r     <= SILENCE;
            end else begin
              if (wr_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
              end
              if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
                d_l    <= rd_data_s[15:0];
                d_r    <= rd_data_s[31:16];
              end
              case ({wr_ok_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
              endcase
              if (state_r == RUN) begin
                if (unf_set_s) begin
                  state_r <= UNDERRUN;
                end
              end else if (level_r >= PRIME_LVL) begin
                state_r <= RUN;
              end
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign host.fifo_full  = full_s;
  assign host.fifo_level = level_r;
  assign host.refill_req = (level_r < HALF_LVL) &&
                           ((state_r == PRIME) || (state_r == RUN) || (state_r == UNDERRUN));
endmodule

// File: tb/tb_audio_dac_sequencer.sv
// Directed self-checking bench for audio_dac_sequencer; inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_audio_dac_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        shutdown_req;
  logic [15:0] rate_div;
  logic        clr_flags;
  logic [15:0] d_l;
  logic [15:0] d_r;
  logic        terminate;
  logic        underrun;
  logic        overflow;
  int          checks = 0;
  int          failures = 0;

  audio_dac_sequencer_if #(.FIFO_AW(4)) bus ();

  audio_dac_sequencer #(.FIFO_AW(4), .PRIME_LEVEL(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .shutdown_req (shutdown_req),
    .rate_div     (rate_div),
    .clr_flags    (clr_flags),
    .host         (bus),
    .d_l          (d_l),
    .d_r          (d_r),
    .terminate    (terminate),
    .underrun     (underrun),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    cyc();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; shutdown_req = 1'b0; rate_div = 16'd3; clr_flags = 1'b0;
    bus.wr_en = 1'b0; bus.wr_data = 32'd0;
    repeat (2) cyc();
    chk("rst_dl", 32'(d_l), 32'h8000);
    chk("rst_dr", 32'(d_r), 32'h8000);
    chk("rst_term", 32'(terminate), 32'd0);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_full", 32'(bus.fifo_full), 32'd0);
    chk("rst_unf", 32'(underrun), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_refill", 32'(bus.refill_req), 32'd0);

    // Edge 1 enters PRIME; ticks land on edges 1,5,9,...
    reset = 1'b0; enable = 1'b1;
    cyc();
    chk("prime_refill", 32'(bus.refill_req), 32'd1);
    for (int i = 1; i <= 8; i++) push({16'(i), 16'(i)});
    chk("prime_level", 32'(bus.fifo_level), 32'd8);
    chk("prime_refill8", 32'(bus.refill_req), 32'd0);
    repeat (3) cyc();
    chk("run_hold", 32'(d_l), 32'h8000);
    cyc();
    chk("run_first_l", 32'(d_l), 32'd1);
    chk("run_first_r", 32'(d_r), 32'd1);
    chk("run_first_lvl", 32'(bus.fifo_level), 32'd7);
    for (int k = 2; k <= 8; k++) begin
      repeat (3) cyc();
      chk("run_step_hold", 32'(d_l), 32'(k - 1));
      cyc();
      chk("run_step", 32'(d_l), 32'(k));
    end
    chk("run_drained", 32'(bus.fifo_level), 32'd0);

    repeat (3) cyc();
    chk("pre_unf", 32'(underrun), 32'd0);
    cyc();
    chk("unf_flag", 32'(underrun), 32'd1);
    chk("unf_hold", 32'(d_l), 32'd8);
    for (int i = 9; i <= 16; i++) push({16'(i), 16'(i)});
    chk("unf_level", 32'(bus.fifo_level), 32'd8);
    repeat (3) cyc();
    chk("unf_resume_hold", 32'(d_l), 32'd8);
    cyc();
    chk("unf_resume_l", 32'(d_l), 32'd9);
    chk("unf_resume_r", 32'(d_r), 32'd9);
    chk("unf_resume_lvl", 32'(bus.fifo_level), 32'd7);

    enable = 1'b0;
    cyc();
    chk("dis_dl", 32'(d_l), 32'h8000);
    chk("dis_dr", 32'(d_r), 32'h8000);
    chk("dis_level", 32'(bus.fifo_level), 32'd0);
    chk("dis_refill", 32'(bus.refill_req), 32'd0);
    chk("dis_unf_sticky", 32'(underrun), 32'd1);
    rate_div = 16'd999; clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    chk("clr_unf", 32'(underrun), 32'd0);

    // Tick on edge 61 reloads 999, so the next tick is edge 1061.
    repeat (4) cyc();
    enable = 1'b1;
    cyc();
    for (int i = 1; i <= 17; i++) push({16'(16'h0100 + i), 16'(16'h0100 + i)});
    chk("ovf_level", 32'(bus.fifo_level), 32'd16);
    chk("ovf_full", 32'(bus.fifo_full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_refill", 32'(bus.refill_req), 32'd0);
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    rate_div = 16'd3;
    repeat (978) cyc();
    chk("full_run_hold", 32'(d_l), 32'h8000);
    chk("full_run_ovf0", 32'(overflow), 32'd0);
    bus.wr_en = 1'b1; bus.wr_data = 32'hDEAD_BEEF; clr_flags = 1'b1;
    cyc();
    bus.wr_en = 1'b0; clr_flags = 1'b0;
    chk("tick_ovf_setwins", 32'(overflow), 32'd1);
    chk("tick_ovf_level", 32'(bus.fifo_level), 32'd15);
    chk("tick_ovf_full", 32'(bus.fifo_full), 32'd0);
    chk("tick_pop_l", 32'(d_l), 32'h0101);
    chk("tick_pop_r", 32'(d_r), 32'h0101);

    shutdown_req = 1'b1; enable = 1'b1;
    cyc();
    chk("sd_term", 32'(terminate), 32'd1);
    chk("sd_dl", 32'(d_l), 32'h8000);
    chk("sd_level", 32'(bus.fifo_level), 32'd0);
    shutdown_req = 1'b0;
    push(32'h1234_5678);
    cyc();
    chk("sd_wr_ignored", 32'(bus.fifo_level), 32'd0);
    chk("sd_term_sticky", 32'(terminate), 32'd1);
    chk("sd_refill", 32'(bus.refill_req), 32'd0);
    chk("sd_ovf_sticky", 32'(overflow), 32'd1);
    reset = 1'b1;
    cyc();
    chk("rst2_term", 32'(terminate), 32'd0);
    chk("rst2_ovf", 32'(overflow), 32'd0);
    chk("rst2_dl", 32'(d_l), 32'h8000);

    // rate_div=0: a tick every cycle, then an empty-FIFO write racing a tick.
    rate_div = 16'd0; reset = 1'b0; enable = 1'b1;
    cyc();
    for (int i = 1; i <= 8; i++) push({16'(16'h0020 + i), 16'(16'h0020 + i)});
    cyc();
    chk("r0_hold", 32'(d_l), 32'h8000);
    cyc();
    chk("r0_pop1", 32'(d_l), 32'h0021);
    cyc();
    chk("r0_pop2", 32'(d_l), 32'h0022);
    repeat (6) cyc();
    chk("r0_pop8", 32'(d_l), 32'h0028);
    chk("r0_empty", 32'(bus.fifo_level), 32'd0);
    chk("r0_no_unf", 32'(underrun), 32'd0);
    push(32'h0099_0099);
    chk("r0_nobypass_unf", 32'(underrun), 32'd1);
    chk("r0_nobypass_lvl", 32'(bus.fifo_level), 32'd1);
    chk("r0_nobypass_dl", 32'(d_l), 32'h0028);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
